// File: rtl/cam_power_seq.sv
// Camera sensor power-up sequencer: qualifies PLL lock, then steps XCLK/PWDN/RESET/settle
// before releasing sys_rst. Optional lock-loss counter under CAM_LOCK_LOSS_CNT_EN.
module cam_power_seq #(
  parameter int LOCK_CYCLES   = 1024,
  parameter int PWDN_CYCLES   = 24000,
  parameter int RST_CYCLES    = 24000,
  parameter int SETTLE_CYCLES = 480000,
  parameter int CNT_W         = 20
) (
  input  logic clkin,
  input  logic reset,
  input  logic lock,
  input  logic sw_restart,
  output logic cam_xclk_en,
  output logic cam_pwdn,
  output logic cam_rstn,
  output logic sys_rst,
  output logic ready
`ifdef CAM_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PWDN_HOLD = 3'd1,
    RST_HOLD  = 3'd2,
    SETTLE    = 3'd3,
    READY     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_meta_q, lock_s_q;
  logic             loss_evt;

  // Output vector {xclk_en, pwdn, rstn, sys_rst, ready} for a given state.
  function automatic logic [4:0] outs_of(input state_t s);
    case (s)
      PWDN_HOLD: return 5'b11010;
      RST_HOLD:  return 5'b10010;
      SETTLE:    return 5'b10110;
      READY:     return 5'b10101;
      default:   return 5'b01010;
    endcase
  endfunction

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign loss_evt = (state_q != WAIT_LOCK) && !lock_s_q;

  // Lock loss outranks sw_restart so a coincident pair is recorded as a loss.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (loss_evt || sw_restart) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!lock_s_q) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = PWDN_HOLD;
            cnt_d   = '0;
          end
        end
        PWDN_HOLD: begin
          if (cnt_q == PWDN_LAST) begin
            state_d = RST_HOLD;
            cnt_d   = '0;
          end
        end
        RST_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = READY;
            cnt_d   = '0;
          end
        end
        READY: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      {cam_xclk_en, cam_pwdn, cam_rstn, sys_rst, ready} <= 5'b01010;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      {cam_xclk_en, cam_pwdn, cam_rstn, sys_rst, ready} <= outs_of(state_d);
    end
  end

`ifdef CAM_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      loss_cnt_q <= 8'd0;
    end else if (loss_evt && (state_q == READY) && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule
